// File: rtl/jtag_host_engine.sv
// Command-driven JTAG initiator: walks the TAP through IR scans, DR scans and
// test-logic resets, generating TCK/TMS/TDI from clk and capturing TDO per shifted bit.
module jtag_host_engine #(
  parameter int DIV    = 2,
  parameter int W_DATA = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [$clog2(W_DATA)-1:0] cmd_len,
  input  logic [W_DATA-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [W_DATA-1:0]         rsp_rdata,
  output logic                      tck,
  output logic                      tms,
  output logic                      tdi,
  input  logic                      tdo
);
  localparam int LEN_W = $clog2(W_DATA);
  localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(W_DATA - 1);
  // TMS values for the bits following the first (which is always 1), next bit in the LSB.
  localparam logic [5:0] SEQ_DR  = 6'b000000;
  localparam logic [5:0] SEQ_IR  = 6'b000001;
  localparam logic [5:0] SEQ_RST = 6'b001111;

  typedef enum logic [2:0] {INIT, IDLE, HEAD, SHIFT, TAIL, RSP} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [5:0]        seq;
  logic              tap_rst_q;
  logic [LEN_W-1:0]  len_q;
  logic [W_DATA-1:0] wdata_q;
  logic [W_DATA-1:0] cap_q;

  // The capture register fills from the MSB end; move bit 0 of the scan down to bit 0.
  function automatic logic [W_DATA-1:0] align_capture(input logic [W_DATA-1:0] cap,
                                                      input logic [LEN_W-1:0]  len);
    return cap >> (LEN_MAX - len);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      div_cnt   <= '0;
      bit_cnt   <= CNT_W'(5);
      seq       <= SEQ_RST;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            tap_rst_q <= (cmd_op == 2'd2) || (cmd_op == 2'd3);
            len_q     <= cmd_len;
            wdata_q   <= cmd_wdata;
            cap_q     <= '0;
            div_cnt   <= '0;
            tck       <= 1'b0;
            tdi       <= 1'b0;
            tms       <= 1'b1;
            state     <= HEAD;
            case (cmd_op)
              2'd0:    begin seq <= SEQ_DR;  bit_cnt <= CNT_W'(2); end
              2'd1:    begin seq <= SEQ_IR;  bit_cnt <= CNT_W'(3); end
              default: begin seq <= SEQ_RST; bit_cnt <= CNT_W'(5); end
            endcase
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        INIT, HEAD, SHIFT, TAIL: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!tck) begin
              tck <= 1'b1;
              if (state == SHIFT) cap_q <= {tdo, cap_q[W_DATA-1:1]};
            end else begin
              // End of a bit period: start the next bit or move to the next phase.
              tck <= 1'b0;
              if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - CNT_W'(1);
                if (state == SHIFT) begin
                  tdi     <= wdata_q[0];
                  wdata_q <= wdata_q >> 1;
                  tms     <= (bit_cnt == CNT_W'(1));
                end else begin
                  tms <= seq[0];
                  seq <= seq >> 1;
                end
              end else begin
                case (state)
                  INIT: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                  end
                  HEAD: begin
                    if (tap_rst_q) begin
                      state     <= RSP;
                      rsp_valid <= 1'b1;
                      rsp_rdata <= '0;
                    end else begin
                      state   <= SHIFT;
                      tdi     <= wdata_q[0];
                      wdata_q <= wdata_q >> 1;
                      tms     <= (len_q == '0);
                      bit_cnt <= CNT_W'(len_q);
                    end
                  end
                  SHIFT: begin
                    state   <= TAIL;
                    tdi     <= 1'b0;
                    tms     <= 1'b1;
                    seq     <= '0;
                    bit_cnt <= CNT_W'(1);
                  end
                  default: begin
                    state     <= RSP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= align_capture(cap_q, len_q);
                  end
                endcase
              end
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_host_engine.sv
// Directed bench for jtag_host_engine: a behavioural TAP (IDCODE 0xdeadbeef, 5-bit IR,
// bypass) sits on the JTAG pins; scans are checked against hand-computed values.
module tb_jtag_host_engine;
  localparam int DIV = 2;
  localparam int W   = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [4:0]  cmd_len = 5'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        tdo = 1'b0;
  logic        cmd_ready, rsp_valid, tck, tms, tdi;
  logic [31:0] rsp_rdata;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  jtag_host_engine #(.DIV(DIV), .W_DATA(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  // Behavioural TAP controller
  typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
                            SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR} tap_t;
  tap_t        tap = TLR;
  logic [4:0]  ir = 5'd1;
  logic [4:0]  ir_sr = 5'd0;
  logic [31:0] dr_sr = 32'd0;
  logic        byp = 1'b0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PA_DR;
      PA_DR:   return m ? EX2_DR : PA_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PA_IR;
      PA_IR:   return m ? EX2_IR : PA_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap)
      TLR:    ir <= 5'd1;
      CAP_DR: begin dr_sr <= 32'hdeadbeef; byp <= 1'b0; end
      SH_DR:  if (ir == 5'd1) dr_sr <= {tdi, dr_sr[31:1]}; else byp <= tdi;
      CAP_IR: ir_sr <= 5'b00001;
      SH_IR:  ir_sr <= {tdi, ir_sr[4:1]};
      UPD_IR: ir <= ir_sr;
      default: ;
    endcase
    tap <= tap_next(tap, tms);
  end

  always @(negedge tck) begin
    if (tap == SH_DR)      tdo <= (ir == 5'd1) ? dr_sr[0] : byp;
    else if (tap == SH_IR) tdo <= ir_sr[0];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered at the negedge where rst has just been dropped.
  task automatic init_watch(input string tag);
    int cyc, nrise, ready_at, tdi_hi, vld_hi;
    logic prev;
    logic [63:0] pat;
    cyc = 0; nrise = 0; ready_at = -1; tdi_hi = 0; vld_hi = 0; prev = tck; pat = '0;
    while (ready_at < 0 && cyc < 200) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (tck && !prev) begin
        if (nrise < 64) pat[nrise] = tms;
        nrise++;
      end
      prev = tck;
      if (tdi) tdi_hi++;
      if (rsp_valid) vld_hi++;
      if (cmd_ready) ready_at = cyc;
    end
    check({tag, "_ready_cycle"}, 64'(ready_at), 64'd24);
    check({tag, "_pulses"}, 64'(nrise), 64'd6);
    check({tag, "_tms"}, pat, 64'h1f);
    check({tag, "_tdi_high"}, 64'(tdi_hi), 64'd0);
    check({tag, "_rsp_valid"}, 64'(vld_hi), 64'd0);
    check({tag, "_tap_rti"}, 64'(tap), 64'(RTI));
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] len, input logic [31:0] wd);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    check("cmd_ready_wait", 64'(n >= 200), 64'd0);
    cmd_op = op; cmd_len = len; cmd_wdata = wd; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int hold, output logic [31:0] rd,
                          output int lat, output int nrise,
                          output logic [63:0] tms_pat, output logic [63:0] tdi_pat);
    logic prev;
    int unstable, rdy_hi;
    lat = 0; nrise = 0; tms_pat = '0; tdi_pat = '0; prev = tck; unstable = 0; rdy_hi = 0;
    while (!rsp_valid && lat < 1000) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (tck && !prev) begin
        if (nrise < 64) begin tms_pat[nrise] = tms; tdi_pat[nrise] = tdi; end
        nrise++;
      end
      prev = tck;
    end
    check({tag, "_timeout"}, 64'(lat >= 1000), 64'd0);
    check({tag, "_ready_in_rsp"}, 64'(cmd_ready), 64'd0);
    rd = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== rd) unstable++;
      if (cmd_ready) rdy_hi++;
    end
    if (hold > 0) begin
      check({tag, "_bp_unstable"}, 64'(unstable), 64'd0);
      check({tag, "_bp_ready"}, 64'(rdy_hi), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_ready_after_hs"}, 64'(cmd_ready), 64'd1);
    check({tag, "_valid_after_hs"}, 64'(rsp_valid), 64'd0);
    check({tag, "_tap_rti"}, 64'(tap), 64'(RTI));
  endtask

  task automatic do_scan(input string tag, input logic [1:0] op, input logic [4:0] len,
                         input logic [31:0] wd, input int hold, input logic [31:0] exp_rd,
                         input int exp_lat, input int exp_pulses,
                         output logic [63:0] tp, output logic [63:0] dp);
    logic [31:0] rd;
    int lat, np;
    issue(op, len, wd);
    wait_rsp(tag, hold, rd, lat, np, tp, dp);
    check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_pulses"}, 64'(np), 64'(exp_pulses));
  endtask

  initial begin
    logic [63:0] tp, dp;
    logic prev;
    int nr, guard;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pins", 64'({tck, tms, tdi}), 64'(3'b010));
    check("rst_handshake", 64'({cmd_ready, rsp_valid}), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    rst = 1'b0;
    init_watch("init");

    // IDCODE read
    do_scan("ir_idcode", 2'd1, 5'd4, 32'h01, 0, 32'h01, 44, 11, tp, dp);
    do_scan("dr_idcode", 2'd0, 5'd31, 32'h0, 0, 32'hdeadbeef, 148, 37, tp, dp);

    // Select BYPASS, then loopback scans
    do_scan("ir_bypass", 2'd1, 5'd4, 32'h1f, 0, 32'h01, 44, 11, tp, dp);
    do_scan("dr8", 2'd0, 5'd7, 32'h5a, 0, 32'hb4, 52, 13, tp, dp);
    check("dr8_tms", tp, 64'hc01);
    check("dr8_tdi", dp, 64'h2d0);
    do_scan("lb1", 2'd0, 5'd0, 32'ha5a5a5a5, 0, 32'h0, 24, 6, tp, dp);
    check("lb1_tms", tp, 64'h19);
    check("lb1_tdi", dp, 64'h8);
    do_scan("lb7", 2'd0, 5'd6, 32'ha5a5a5a5, 0, 32'h4a, 48, 12, tp, dp);
    do_scan("lb32", 2'd0, 5'd31, 32'ha5a5a5a5, 0, 32'h4b4b4b4a, 148, 37, tp, dp);

    // Backpressure
    do_scan("bp", 2'd0, 5'd6, 32'ha5a5a5a5, 20, 32'h4a, 48, 12, tp, dp);

    // TAP reset commands; TLR puts IDCODE back in the IR
    do_scan("tap_rst", 2'd2, 5'd5, 32'hffffffff, 0, 32'h0, 24, 6, tp, dp);
    check("tap_rst_tms", tp, 64'h1f);
    check("tap_rst_tdi", dp, 64'h0);
    do_scan("dr_id2", 2'd0, 5'd31, 32'h0, 0, 32'hdeadbeef, 148, 37, tp, dp);
    do_scan("op3", 2'd3, 5'd31, 32'h12345678, 0, 32'h0, 24, 6, tp, dp);
    check("op3_tms", tp, 64'h1f);
    do_scan("dr_id3", 2'd0, 5'd31, 32'h0, 0, 32'hdeadbeef, 148, 37, tp, dp);

    // Reset during SHIFT bit 10 of a 32-bit DR scan (pulse index 13)
    issue(2'd0, 5'd31, 32'h12345678);
    nr = 0; guard = 0; prev = tck;
    while (nr < 14 && guard < 500) begin
      @(posedge clk); guard++;
      @(negedge clk);
      if (tck && !prev) nr++;
      prev = tck;
    end
    check("mid_rst_reach_bit10", 64'(nr), 64'd14);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_pins", 64'({tck, tms, rsp_valid}), 64'(3'b010));
    check("mid_rst_rdata", 64'(rsp_rdata), 64'd0);
    rst = 1'b0;
    init_watch("reinit");
    do_scan("dr_after_rst", 2'd0, 5'd31, 32'h0, 0, 32'hdeadbeef, 148, 37, tp, dp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end
endmodule
